cpu_data_mem_responder: RTL and testbench

- Memory-side responder for the single-cycle RV32I core's data port. It consumes the core's address, store data and load/store flags, and returns load data in the same cycle.
- Contains a byte-addressable data RAM with LB/LH/LW/LBU/LHU/SB/SH/SW lane handling, alignment checking, and a small MMIO window.
- The MMIO window holds a UART transmitter (FSM-driven), its status register, and a free-running cycle counter.

---
 rtl/cpu_data_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_cpu_data_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_data_mem_responder.sv
// Data-port responder for the single-cycle RV32I core: byte-addressable RAM with
// RV32I load/store lane handling, plus an MMIO window holding a UART transmitter and a cycle counter.
module cpu_data_mem_responder #(
  parameter int          RAM_WORDS    = 1024,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [15:0] MMIO_HI      = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] to_memory,
  input  logic        memload_flag,
  input  logic        memstore_flag,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] from_memory,
  output logic        misaligned,
  output logic        uart_tx,
  output logic        uart_busy
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CYCLE  = 16'h0008;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t   state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          overflow;
  logic [31:0]   cycle_cnt;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;
  logic [31:0]   mmio_word;
  logic          access, is_mmio, align_err, ok_store;
  logic          ram_we, tx_write, tx_accept, status_clear;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic [15:0]   mmio_off;

  // Sign/zero extension of the addressed byte or halfword out of a 32-bit word.
  function automatic logic [31:0] load_view(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_view = {{24{b[7]}}, b};
      3'b001:  load_view = {{16{h[15]}}, h};
      3'b100:  load_view = {24'h0, b};
      3'b101:  load_view = {16'h0, h};
      default: load_view = w;
    endcase
  endfunction

  assign access    = memload_flag | memstore_flag;
  assign is_mmio   = (memory_address[31:16] == MMIO_HI);
  assign mmio_off  = memory_address[15:0];
  assign align_err = ((mem_funct3[1:0] == 2'b01) && memory_address[0]) ||
                     ((mem_funct3[1:0] == 2'b10) && (memory_address[1:0] != 2'b00));
  assign misaligned = access & align_err;
  assign ok_store   = memstore_flag & ~align_err;

  assign ram_idx  = memory_address[2 +: AW];
  assign ram_word = ram[ram_idx];

  assign uart_busy    = (state != IDLE);
  assign ram_we       = ok_store & ~is_mmio;
  assign tx_write     = ok_store & is_mmio & (mmio_off == OFF_TXDATA);
  assign tx_accept    = tx_write & ~uart_busy;
  assign status_clear = ok_store & is_mmio & (mmio_off == OFF_STATUS) & to_memory[1];

  always_comb begin
    mmio_word = 32'h0;
    case (mmio_off)
      OFF_STATUS: mmio_word = {30'h0, overflow, uart_busy};
      OFF_CYCLE:  mmio_word = cycle_cnt;
      default:    mmio_word = 32'h0;
    endcase
  end

  always_comb begin
    from_memory = 32'h0;
    if (memload_flag && !align_err)
      from_memory = load_view(is_mmio ? mmio_word : ram_word, mem_funct3, memory_address[1:0]);
  end

  // Narrow stores replicate their data across the word so only the byte enables differ.
  always_comb begin
    byte_en = 4'b1111;
    wdata   = to_memory;
    case (mem_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << memory_address[1:0];
        wdata   = {4{to_memory[7:0]}};
      end
      2'b01: begin
        byte_en = memory_address[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{to_memory[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = to_memory;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) ram[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      cycle_cnt <= 32'h0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (tx_write && uart_busy) overflow <= 1'b1;
      else if (status_clear)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'h0;
      shreg    <= 8'h0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      uart_tx  <= tx_n;
    end
  end

  // uart_tx is registered from the next-state view so it changes together with the state.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    case (state)
      IDLE: begin
        if (tx_accept) begin
          state_n    = START;
          baud_cnt_n = '0;
          bit_cnt_n  = 3'h0;
          shreg_n    = to_memory[7:0];
        end
      end
      START: begin
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          state_n    = DATA;
        end else baud_cnt_n = baud_cnt + 1'b1;
      end
      DATA: begin
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[7:1]};
          bit_cnt_n  = bit_cnt + 3'h1;
          if (bit_cnt == 3'h7) state_n = STOP;
        end else baud_cnt_n = baud_cnt + 1'b1;
      end
      STOP: begin
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
        end else baud_cnt_n = baud_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Directed bench for cpu_data_mem_responder: RAM load/store vector table plus
// hand-written UART frame, overflow, cycle-counter and reset sequences.
module tb_cpu_data_mem_responder;

  localparam int CPB = 4;
  localparam logic [31:0] TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE  = 32'hFFFF_0008;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic [31:0] memory_address, to_memory, from_memory;
  logic        memload_flag, memstore_flag, misaligned, uart_tx, uart_busy;
  logic [2:0]  mem_funct3;

  int total = 0;
  int bad   = 0;

  cpu_data_mem_responder #(.RAM_WORDS(1024), .CLKS_PER_BIT(CPB), .MMIO_HI(16'hFFFF)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .memory_address(memory_address),
    .to_memory(to_memory), .memload_flag(memload_flag), .memstore_flag(memstore_flag),
    .mem_funct3(mem_funct3), .from_memory(from_memory), .misaligned(misaligned),
    .uart_tx(uart_tx), .uart_busy(uart_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] ed, input logic em);
    vec_t v;
    v.name = n; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_data = ed; v.exp_mis = em;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    memload_flag   = ld;
    memstore_flag  = st;
    mem_funct3     = f3;
    memory_address = addr;
    to_memory      = wd;
  endtask

  // One frame of data; with inject set, a second TXDATA store lands mid-frame.
  task automatic runFrame(input logic [7:0] data, input bit inject, input logic ovf_start);
    logic ovf_exp;
    logic exp_bit;
    ovf_exp = ovf_start;
    applyStimulus(1'b0, 1'b1, 3'b010, TXDATA, {24'h0, data});
    #1;
    checkOutput("busy_before_frame", {31'h0, uart_busy}, 32'h0);
    @(posedge sys_clk); #1;
    for (int k = 0; k < 10 * CPB; k++) begin
      int j;
      if (inject && k == 5) applyStimulus(1'b0, 1'b1, 3'b010, TXDATA, 32'h0000_00FF);
      else                  applyStimulus(1'b1, 1'b0, 3'b010, STATUS, 32'h0);
      #1;
      j = k / CPB;
      exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : data[j-1];
      checkOutput($sformatf("tx_bit_cycle%0d", k), {31'h0, uart_tx}, {31'h0, exp_bit});
      checkOutput($sformatf("busy_cycle%0d", k), {31'h0, uart_busy}, 32'h1);
      if (inject && k == 5) ovf_exp = 1'b1;
      else checkOutput($sformatf("status_cycle%0d", k), from_memory, {30'h0, ovf_exp, 1'b1});
      @(posedge sys_clk); #1;
    end
    applyStimulus(1'b1, 1'b0, 3'b010, STATUS, 32'h0);
    #1;
    checkOutput("busy_after_frame", {31'h0, uart_busy}, 32'h0);
    checkOutput("tx_after_frame", {31'h0, uart_tx}, 32'h1);
    checkOutput("status_after_frame", from_memory, {30'h0, ovf_exp, 1'b0});
    @(posedge sys_clk); #1;
  endtask

  initial begin
    vecs.push_back(mk("sw_800000ff", 0, 1, 3'b010, 32'h100, 32'h8000_00FF, 32'h0, 0));
    vecs.push_back(mk("lb_100",      1, 0, 3'b000, 32'h100, 32'h0, 32'hFFFF_FFFF, 0));
    vecs.push_back(mk("lbu_100",     1, 0, 3'b100, 32'h100, 32'h0, 32'h0000_00FF, 0));
    vecs.push_back(mk("lh_100",      1, 0, 3'b001, 32'h100, 32'h0, 32'h0000_00FF, 0));
    vecs.push_back(mk("lb_103",      1, 0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF80, 0));
    vecs.push_back(mk("lbu_103",     1, 0, 3'b100, 32'h103, 32'h0, 32'h0000_0080, 0));
    vecs.push_back(mk("lw_100",      1, 0, 3'b010, 32'h100, 32'h0, 32'h8000_00FF, 0));
    vecs.push_back(mk("lhu_102",     1, 0, 3'b101, 32'h102, 32'h0, 32'h0000_8000, 0));
    vecs.push_back(mk("lh_102",      1, 0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8000, 0));
    vecs.push_back(mk("sw_zero",     0, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0));
    vecs.push_back(mk("sb_101",      0, 1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 0));
    vecs.push_back(mk("sh_102",      0, 1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 0));
    vecs.push_back(mk("lw_merged",   1, 0, 3'b010, 32'h100, 32'h0, 32'h1234_AB00, 0));
    vecs.push_back(mk("sw_1000",     0, 1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0));
    vecs.push_back(mk("lw_alias",    1, 0, 3'b010, 32'h2000, 32'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("sh_mis",      0, 1, 3'b001, 32'h101, 32'h0000_FFFF, 32'h0, 1));
    vecs.push_back(mk("lw_mis",      1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1));
    vecs.push_back(mk("lw_unchanged",1, 0, 3'b010, 32'h100, 32'h0, 32'h1234_AB00, 0));
    vecs.push_back(mk("ld_st_same",  1, 1, 3'b010, 32'h100, 32'h1122_3344, 32'h1234_AB00, 0));
    vecs.push_back(mk("lw_after_ls", 1, 0, 3'b010, 32'h100, 32'h0, 32'h1122_3344, 0));
    vecs.push_back(mk("idle_nomis",  0, 0, 3'b010, 32'h103, 32'h0, 32'h0, 0));
    vecs.push_back(mk("lw_status0",  1, 0, 3'b010, STATUS, 32'h0, 32'h0, 0));
    vecs.push_back(mk("lw_txdata",   1, 0, 3'b010, TXDATA, 32'h0, 32'h0, 0));
    vecs.push_back(mk("lw_mmio_oth", 1, 0, 3'b010, 32'hFFFF_0010, 32'h0, 32'h0, 0));

    sys_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    checkOutput("reset_tx", {31'h0, uart_tx}, 32'h1);
    checkOutput("reset_busy", {31'h0, uart_busy}, 32'h0);
    checkOutput("reset_from_memory", from_memory, 32'h0);
    checkOutput("reset_misaligned", {31'h0, misaligned}, 32'h0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, CYCLE, 32'h0);
    repeat (10) @(posedge sys_clk);
    #1;
    checkOutput("cycle_after_10", from_memory, 32'd10);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput({vecs[i].name, "_data"}, from_memory, vecs[i].exp_data);
      checkOutput({vecs[i].name, "_mis"}, {31'h0, misaligned}, {31'h0, vecs[i].exp_mis});
      @(posedge sys_clk); #1;
    end

    runFrame(8'hA5, 1'b0, 1'b0);
    runFrame(8'h5A, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 3'b010, STATUS, 32'h0000_0002);
    @(posedge sys_clk); #1;
    applyStimulus(1'b1, 1'b0, 3'b010, STATUS, 32'h0);
    #1;
    checkOutput("status_cleared", from_memory, 32'h0);

    applyStimulus(1'b0, 1'b1, 3'b010, TXDATA, 32'h0000_003C);
    @(posedge sys_clk); #1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (15) @(posedge sys_clk);
    #1;
    checkOutput("busy_mid_frame", {31'h0, uart_busy}, 32'h1);
    applyStimulus(1'b1, 1'b0, 3'b010, CYCLE, 32'h0);
    sys_reset = 1'b1;
    #1;
    checkOutput("reset_mid_tx", {31'h0, uart_tx}, 32'h1);
    checkOutput("reset_mid_busy", {31'h0, uart_busy}, 32'h0);
    checkOutput("reset_mid_cycle", from_memory, 32'h0);
    @(negedge sys_clk);
    sys_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
